// File: rtl/nsa_pkg.sv
// Shared definitions for the nibble-serial adder: FSM state type,
// nibble size and the index-counter width helper.
package nsa_pkg;

   localparam int NIBBLE = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2
   } nsa_state_t;

   // One nibble still needs a 1-bit index so the counter never collapses to zero width.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/cla4_slice.sv
// Purely combinational 4-bit carry-lookahead adder built from
// propagate/generate terms.
module cla4_slice (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       ci,
   output logic [3:0] s,
   output logic       co
);

   logic [3:0] p;
   logic [3:0] g;
   logic [4:0] c;

   // Flattened lookahead carries; no ripple through the slice.
   always_comb begin
      p    = a ^ b;
      g    = a & b;
      c[0] = ci;
      c[1] = g[0] | (p[0] & ci);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
      c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & ci);
      s    = p ^ c[3:0];
      co   = c[4];
   end

endmodule

// File: rtl/nibble_serial_adder.sv
// Sequential WIDTH-bit adder: one 4-bit CLA slice is reused once per
// nibble, carry registered between nibbles, valid/ready on both sides.
// Optional feature macro: NSA_OVERFLOW_EN adds the signed-overflow output ovf.
//
// state | meaning
// IDLE  | waiting for operands, in_ready=1
// RUN   | adding one nibble per clock
// HOLD  | result valid, waiting for out_ready
module nibble_serial_adder
   import nsa_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             ci,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             co
`ifdef NSA_OVERFLOW_EN
   ,
   output logic             ovf
`endif
);

   localparam int N    = WIDTH / NIBBLE;
   localparam int IDXW = idx_width(N);
   localparam logic [IDXW-1:0] LAST = IDXW'(N - 1);

   if ((WIDTH % NIBBLE) != 0 || WIDTH < NIBBLE) begin : g_bad_width
      $error("nibble_serial_adder: WIDTH must be a multiple of 4 and at least 4");
   end

   nsa_state_t       state;
   nsa_state_t       state_next;
   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic [WIDTH-1:0] sum_reg;
   logic             carry;
   logic             co_reg;
   logic [IDXW-1:0]  idx;
   logic [3:0]       nib_a;
   logic [3:0]       nib_b;
   logic [3:0]       nib_s;
   logic             nib_co;
   logic             accept;
   logic             last;

   assign accept = in_valid && in_ready;
   assign last   = (state == RUN) && (idx == LAST);
   assign nib_a  = a_reg[int'(idx)*NIBBLE +: NIBBLE];
   assign nib_b  = b_reg[int'(idx)*NIBBLE +: NIBBLE];

   cla4_slice u_slice (
      .a  (nib_a),
      .b  (nib_b),
      .ci (carry),
      .s  (nib_s),
      .co (nib_co)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   // Next-state logic.
   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:    if (accept) state_next = RUN;
         RUN:     if (last) state_next = HOLD;
         HOLD:    if (out_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Handshake outputs; in_ready is gated by rst_n so it is low throughout reset.
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      unique case (state)
         IDLE:    in_ready  = rst_n;
         HOLD:    out_valid = 1'b1;
         default: ;
      endcase
   end

   // Operand capture, per-nibble sum/carry update and the final carry-out.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_reg   <= '0;
         b_reg   <= '0;
         sum_reg <= '0;
         carry   <= 1'b0;
         co_reg  <= 1'b0;
         idx     <= '0;
      end else if (accept) begin
         a_reg <= a;
         b_reg <= b;
         carry <= ci;
         idx   <= '0;
      end else if (state == RUN) begin
         sum_reg[int'(idx)*NIBBLE +: NIBBLE] <= nib_s;
         carry <= nib_co;
         idx   <= idx + 1'b1;
         if (last) co_reg <= nib_co;
      end
   end

`ifdef NSA_OVERFLOW_EN
   logic ovf_reg;

   // Signed overflow: same-sign operands producing an opposite-sign MSB.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    ovf_reg <= 1'b0;
      else if (last) ovf_reg <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) && (nib_s[3] != a_reg[WIDTH-1]);
   end

   assign ovf = ovf_reg;
`endif

   assign sum = sum_reg;
   assign co  = co_reg;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder (WIDTH=16) with a plain
// arithmetic reference model. Define NSA_OVERFLOW_EN to exercise ovf.
module tb_nibble_serial_adder;

   localparam int W = 16;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         ci = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] sum;
   logic         co;
`ifdef NSA_OVERFLOW_EN
   logic         ovf;
`endif

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   nibble_serial_adder #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .ci        (ci),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .co        (co)
`ifdef NSA_OVERFLOW_EN
      ,
      .ovf       (ovf)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_ready();
      int n;
      n = 0;
      while (in_ready !== 1'b1 && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      chk("in_ready_wait", {31'd0, in_ready}, 32'd1);
   endtask

   // Full transaction: accept, check latency, result, hold cycles, release.
   task automatic do_add(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                         input logic tci, input int hold);
      logic [W:0] full;
      logic       exp_ovf;
      full    = {1'b0, ta} + {1'b0, tb_} + {{W{1'b0}}, tci};
      exp_ovf = (ta[W-1] == tb_[W-1]) && (full[W-1] != ta[W-1]);
      wait_ready();
      a = ta; b = tb_; ci = tci; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("run_in_ready", {31'd0, in_ready}, 32'd0);
      chk("run_out_valid0", {31'd0, out_valid}, 32'd0);
      for (int i = 1; i < 4; i++) begin
         @(posedge clk); #1;
         chk("run_out_valid", {31'd0, out_valid}, 32'd0);
      end
      @(posedge clk); #1;
      chk("done_out_valid", {31'd0, out_valid}, 32'd1);
      chk("sum", {16'd0, sum}, {16'd0, full[W-1:0]});
      chk("co", {31'd0, co}, {31'd0, full[W]});
`ifdef NSA_OVERFLOW_EN
      chk("ovf", {31'd0, ovf}, {31'd0, exp_ovf});
`else
      if (exp_ovf) begin end
`endif
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         chk("hold_out_valid", {31'd0, out_valid}, 32'd1);
         chk("hold_sum", {16'd0, sum}, {16'd0, full[W-1:0]});
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("release_out_valid", {31'd0, out_valid}, 32'd0);
      chk("release_in_ready", {31'd0, in_ready}, 32'd1);
      chk("idle_sum_kept", {16'd0, sum}, {16'd0, full[W-1:0]});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      logic [W-1:0] ra, rb;
      logic [W:0]   full;

      // Reset state
      #12;
      chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_sum", {16'd0, sum}, 32'd0);
      chk("rst_co", {31'd0, co}, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      #1;
      chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

      // Directed vectors
      do_add(16'h0000, 16'h0000, 1'b0, 0);
      do_add(16'hFFFF, 16'h0001, 1'b0, 1);
      do_add(16'h1234, 16'h4321, 1'b1, 0);

      // Backpressure with in_valid held high and other operands presented
      wait_ready();
      a = 16'h00F0; b = 16'h0010; ci = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      a = 16'h5555; b = 16'h1111;
      for (int i = 0; i < 4; i++) begin @(posedge clk); #1; end
      chk("bp_first_valid", {31'd0, out_valid}, 32'd1);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
         chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
         chk("bp_sum", {16'd0, sum}, 32'h0100);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("bp_release_valid", {31'd0, out_valid}, 32'd0);
      chk("bp_release_ready", {31'd0, in_ready}, 32'd1);

      // Reset two cycles into RUN
      a = 16'h1111; b = 16'h2222; ci = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("partial_sum", {24'd0, sum[7:0]}, 32'h33);
      rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("midrst_sum", {16'd0, sum}, 32'd0);
      chk("midrst_co", {31'd0, co}, 32'd0);
      chk("midrst_in_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      #1;
      chk("after_rst_in_ready", {31'd0, in_ready}, 32'd1);
      do_add(16'h0003, 16'h0004, 1'b0, 0);
      full = 17'h0;

      // Overflow vectors (also plain sum/co checks without the feature)
      do_add(16'h7FFF, 16'h0001, 1'b0, 0);
      do_add(16'h8000, 16'h8000, 1'b0, 0);
      do_add(16'h0001, 16'h0001, 1'b0, 0);

      // Randomized transactions against the arithmetic model
      for (int t = 0; t < 25; t++) begin
         ra = W'($urandom);
         rb = W'($urandom);
         do_add(ra, rb, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/nibble_serial_adder.md
# nibble_serial_adder

Sequential WIDTH-bit adder that feeds a 4-bit carry-lookahead slice one nibble per clock and collects its sum and carry-out. The carry is registered between nibbles. It sits between an operand source and a result consumer, with valid/ready handshakes on both sides. A WIDTH-bit add costs WIDTH/4 cycles through one 4-bit slice.

## Interface
Parameters:
- WIDTH, 16: operand and sum width. Must be a multiple of 4 and at least 4.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand source presents a, b and ci.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- ci  input  1  carry-in to nibble 0.
- out_valid  output  1  sum and co hold a completed result.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  registered sum.
- co  output  1  registered carry-out of the MSB nibble.
- ovf  output  1  signed overflow. Present only with NSA_OVERFLOW_EN.

## Operation
- Nibble count: N = WIDTH/4.
- Nibble index counter: $clog2(N) bits, minimum 1.
- WIDTH%4 != 0 or WIDTH < 4 is an elaboration $error.
- FSM states:
  - IDLE: in_ready=1, out_valid=0.
  - RUN: in_ready=0, out_valid=0.
  - HOLD: in_ready=0, out_valid=1.
- IDLE, in_valid&&in_ready: latch a, b. Carry register = ci. Index = 0. Go to RUN.
- IDLE, no in_valid: stay in IDLE.
- RUN, each cycle:
  - The slice adds a[4k+3:4k], b[4k+3:4k] and the carry register, where k = index.
  - Slice sum is written to sum[4k+3:4k]; slice carry-out is written to the carry register.
  - Index increments.
- RUN, last nibble (k = N-1): the slice carry-out is also written to co. Go to HOLD.
- HOLD: out_valid&&out_ready → IDLE. Otherwise hold; sum and co stay stable.
- in_valid outside IDLE is ignored. Operands are not buffered.
- sum/co are meaningful only while out_valid=1. In RUN they show partial results. In IDLE they retain the last result.
- Arithmetic is unsigned modulo 2^WIDTH; co is bit WIDTH of a+b+ci.
- Reset values: in_ready=0 while rst_n is low, then 1 (IDLE). out_valid=0, sum=0, co=0, ovf=0. State=IDLE, index=0, carry register=0.
- Reset mid-operation:
  - Asserting rst_n clears all state immediately and asynchronously.
  - The in-flight add is discarded.
  - After deassertion, the first rising edge accepts new operands if in_valid=1.

## Timing
- Accept at edge E. Nibble k registers at edge E+1+k.
- out_valid rises after edge E+N; for WIDTH=16 that is 4 cycles after accept.
- The result stays until out_ready is sampled high. out_valid falls at that edge.
- in_ready rises in the same cycle out_valid falls. The next accept is possible at the following edge.
- Minimum issue interval: N+2 cycles.
- WIDTH=4 (N=1): RUN lasts exactly one cycle.
- The slice is combinational. Its path is one register-to-register stage: carry register and operand nibble through the slice to the sum and carry registers.

## Configuration
- NSA_OVERFLOW_EN defined:
  - Port ovf exists.
  - ovf registers with co, at the last-nibble edge: ovf = (a[WIDTH-1]==b[WIDTH-1]) && (sum[WIDTH-1]!=a[WIDTH-1]).
  - ovf is held like sum.
- NSA_OVERFLOW_EN undefined: no ovf port and no overflow logic. All other behaviour is identical.

## Structure
- Package nsa_pkg:
  - FSM state enum {IDLE, RUN, HOLD}.
  - Constant NIBBLE=4.
  - Function for the index width.
- Sub-module cla4_slice:
  - Purely combinational 4-bit carry-lookahead adder: A[3:0], B[3:0], CI → S[3:0], CO.
  - Built from propagate/generate terms.
  - Instantiated once.
- Top level holds the FSM, operand/sum/carry registers, index counter and the handshake logic.

## Test plan
All scenarios use WIDTH=16.
1. Reset then a=0x0000, b=0x0000, ci=0 → out_valid after 4 cycles; sum=0x0000, co=0.
2. a=0xFFFF, b=0x0001, ci=0 → sum=0x0000, co=1. Checks carry chaining across all four nibbles.
3. a=0x1234, b=0x4321, ci=1 → sum=0x5556, co=0.
4. Backpressure:
   - Stimulus: after 0x00F0+0x0010 completes, hold out_ready=0 for 10 cycles with in_valid=1.
   - Response: sum=0x0100, out_valid=1 and in_ready=0 throughout; no new accept.
   - Release out_ready → IDLE the next cycle.
5. Reset mid-add: assert rst_n=0 two cycles into RUN → out_valid=0, sum=0, co=0 immediately. After release, in_ready=1 and a fresh 0x0003+0x0004 gives 0x0007.
6. NSA_OVERFLOW_EN:
   - 0x7FFF+0x0001 → sum=0x8000, co=0, ovf=1.
   - 0x8000+0x8000 → sum=0x0000, co=1, ovf=1.
   - 0x0001+0x0001 → ovf=0.
